// File: rtl/debug_mem_bridge.sv
// debug_mem_bridge: byte-stream host bridge to the IM/DM debug memory ports.
// Parses opcode/address/data command frames, issues one-cycle word writes or
// synchronous word reads, and streams ACK, ERR or read-data bytes back.
// Ports:
//   CPU_CLK, CPU_RST            clock, async active-low reset
//   cmd_data/valid/ready        command byte stream in
//   rsp_data/valid/ready        response byte stream out
//   busy                        bridge is mid-transaction
//   IM_A2/WD2/WE2/RD2           instruction-RAM debug port
//   DM_A2/WD2/WE2/RD2           data-RAM debug port
module debug_mem_bridge #(
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy,
    output logic [31:0] IM_A2,
    output logic [31:0] IM_WD2,
    output logic [3:0]  IM_WE2,
    input  logic [31:0] IM_RD2,
    output logic [31:0] DM_A2,
    output logic [31:0] DM_WD2,
    output logic [3:0]  DM_WE2,
    input  logic [31:0] DM_RD2
);

    localparam int unsigned WordW  = 32;
    localparam int unsigned ByteW  = 8;
    localparam int unsigned RspCntW = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        READ_REQ,
        READ_WAIT,
        RESP
    } state_t;

    state_t               state;
    logic [1:0]           byteCnt;
    logic                 isWrite;
    logic                 isDm;
    logic [WordW-1:0]     addrReg;
    logic [WordW-1:0]     dataReg;
    logic [3:0]           imWe;
    logic [3:0]           dmWe;
    logic [WordW-1:0]     rspReg;
    logic [RspCntW-1:0]   rspCnt;
    logic                 rspValid;

    // Frame parser, memory sequencer and response shifter.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state    <= IDLE;
            byteCnt  <= 2'd0;
            isWrite  <= 1'b0;
            isDm     <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
            imWe     <= 4'h0;
            dmWe     <= 4'h0;
            rspReg   <= '0;
            rspCnt   <= '0;
            rspValid <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses; only DATA re-arms them.
            imWe <= 4'h0;
            dmWe <= 4'h0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        byteCnt <= 2'd0;
                        case (cmd_data)
                            8'h01: begin isWrite <= 1'b1; isDm <= 1'b0; state <= ADDR; end
                            8'h02: begin isWrite <= 1'b0; isDm <= 1'b0; state <= ADDR; end
                            8'h03: begin isWrite <= 1'b1; isDm <= 1'b1; state <= ADDR; end
                            8'h04: begin isWrite <= 1'b0; isDm <= 1'b1; state <= ADDR; end
                            default: begin
                                rspReg   <= {(WordW-ByteW)'(0), ERR_BYTE};
                                rspCnt   <= RspCntW'(1);
                                rspValid <= 1'b1;
                                state    <= RESP;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (cmd_valid) begin
                        // Little-endian: each new byte enters at the top and shifts down.
                        addrReg <= {cmd_data, addrReg[WordW-1:ByteW]};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            byteCnt <= 2'd0;
                            state   <= isWrite ? DATA : READ_REQ;
                        end
                    end
                end
                DATA: begin
                    if (cmd_valid) begin
                        dataReg <= {cmd_data, dataReg[WordW-1:ByteW]};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            byteCnt <= 2'd0;
                            imWe    <= isDm ? 4'h0 : 4'hF;
                            dmWe    <= isDm ? 4'hF : 4'h0;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    rspReg   <= {(WordW-ByteW)'(0), ACK_BYTE};
                    rspCnt   <= RspCntW'(1);
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                READ_REQ: begin
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    rspReg   <= isDm ? DM_RD2 : IM_RD2;
                    rspCnt   <= RspCntW'(4);
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspReg <= {ByteW'(0), rspReg[WordW-1:ByteW]};
                        rspCnt <= rspCnt - RspCntW'(1);
                        if (rspCnt == RspCntW'(1)) begin
                            rspValid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake/status flags decoded from registered state only.
    assign cmd_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
    assign busy      = (state != IDLE);
    assign rsp_data  = rspReg[ByteW-1:0];
    assign rsp_valid = rspValid;

    // Both ports see the assembled address/data; WE alone qualifies a write.
    assign IM_A2  = addrReg;
    assign IM_WD2 = dataReg;
    assign IM_WE2 = imWe;
    assign DM_A2  = addrReg;
    assign DM_WD2 = dataReg;
    assign DM_WE2 = dmWe;

endmodule
